// File: rtl/fx_div_issue.sv
// fx_div_issue: issue stage for a pipelined fixed-point divider with
// divide-by-zero substitution, in-flight tracking and an FWFT result FIFO. Rev 1.0
`default_nettype none

package fpga_cfg_pkg;
  localparam int FP_WIDTH       = 32;
  localparam int FP_DIV_LATENCY = 4;
endpackage

module fx_div_issue #(
  parameter int WIDTH   = fpga_cfg_pkg::FP_WIDTH,
  parameter int LATENCY = fpga_cfg_pkg::FP_DIV_LATENCY,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic             div_valid_in,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_den,
  input  logic             div_valid_out,
  input  logic [WIDTH-1:0] div_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_dz,
  output logic             err
);

  localparam int               C_DIV_LAT = LATENCY + 2;
  localparam int               C_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               C_CW      = C_AW + 1;
  localparam logic [C_CW-1:0]  C_DEPTH   = C_CW'(DEPTH);
  localparam logic [C_CW-1:0]  C_CNT_ONE = C_CW'(1);
  localparam logic [C_AW-1:0]  C_PTR_ONE = C_AW'(1);
  localparam logic [WIDTH-1:0] C_W_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic pend;
    logic dz;
    logic neg;
    logic zero;
  } trk_t;

  logic [C_CW-1:0]  r_reserved;
  logic             w_accept;
  logic             w_pop;
  logic             w_den_zero;

  assign in_ready   = (r_reserved < C_DEPTH) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_den_zero = (in_den == '0);

  // Reservation covers both in-flight ops and buffered results, so the
  // FIFO can never be overrun by results already committed to the divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reserved <= '0;
    end else if (w_accept && !w_pop) begin
      r_reserved <= r_reserved + C_CNT_ONE;
    end else if (w_pop && !w_accept && (r_reserved != '0)) begin
      r_reserved <= r_reserved - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_valid_in <= 1'b0;
      div_num      <= '0;
      div_den      <= '0;
    end else begin
      div_valid_in <= w_accept;
      if (w_accept) begin
        div_num <= in_num;
        div_den <= w_den_zero ? C_W_ONE : in_den;
      end
    end
  end

  trk_t r_trk [C_DIV_LAT];
  trk_t w_tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_DIV_LAT; i++) begin
        r_trk[i] <= '0;
      end
    end else begin
      r_trk[0].pend <= w_accept;
      r_trk[0].dz   <= w_accept && w_den_zero;
      r_trk[0].neg  <= w_accept && in_num[WIDTH-1];
      r_trk[0].zero <= w_accept && (in_num == '0);
      for (int i = 1; i < C_DIV_LAT; i++) begin
        r_trk[i] <= r_trk[i-1];
      end
    end
  end

  assign w_tail = r_trk[C_DIV_LAT-1];

  logic [WIDTH-1:0] w_sat;
  logic [WIDTH-1:0] w_wdata;

  assign w_sat   = w_tail.zero ? '0 : (w_tail.neg ? C_MIN : C_MAX);
  assign w_wdata = w_tail.dz ? w_sat : div_result;

  logic [WIDTH-1:0] r_mem    [DEPTH];
  logic             r_dz_mem [DEPTH];
  logic [C_AW-1:0]  r_wr;
  logic [C_AW-1:0]  r_rd;
  logic [C_CW-1:0]  r_count;
  logic             w_full;
  logic             w_push;
  logic             w_err_evt;

  assign w_full = (r_count == C_DEPTH);
  assign w_push = div_valid_out && !w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr]    <= w_wdata;
      r_dz_mem[r_wr] <= w_tail.dz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd <= r_rd + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - C_CNT_ONE;
      end
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign out_dz    = out_valid && r_dz_mem[r_rd];

  // Any disagreement between the divider strobe and the tracked tail is a
  // broken latency contract, as is any result arriving with no room.
  assign w_err_evt = (div_valid_out != w_tail.pend) || (div_valid_out && w_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (w_err_evt) begin
      err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fx_div_issue.sv
// tb_fx_div_issue: randomized and directed bench for fx_div_issue with a
// queue-based reference model and a behavioural Q16.16 divider. Rev 1.0
`default_nettype none

module tb_fx_div_issue;

  localparam int W     = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int DLY   = LAT + 1;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_num    = '0;
  logic [W-1:0] in_den    = '0;
  logic         div_valid_in;
  logic [W-1:0] div_num;
  logic [W-1:0] div_den;
  logic         div_valid_out;
  logic [W-1:0] div_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_dz;
  logic         err;
  logic         force_dvo = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  fx_div_issue #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_num       (in_num),
    .in_den       (in_den),
    .div_valid_in (div_valid_in),
    .div_num      (div_num),
    .div_den      (div_den),
    .div_valid_out(div_valid_out),
    .div_result   (div_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dz       (out_dz),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Signed Q16.16 quotient, truncated toward zero.
  function automatic logic [W-1:0] qdiv(input logic [W-1:0] n, input logic [W-1:0] d);
    longint nn;
    longint dd;
    nn = longint'($signed(n)) * 65536;
    dd = longint'($signed(d));
    if (dd == 0) return '1;
    return W'(nn / dd);
  endfunction

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] n, input logic [W-1:0] d);
    if (d != 0) return qdiv(n, d);
    if (n == 0) return '0;
    return n[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  // Divider: strobe-to-result delay of LAT+1 cycles, cleared by rst.
  logic [DLY-1:0] dv_pipe;
  logic [W-1:0]   dr_pipe [DLY];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_pipe <= '0;
    end else begin
      dv_pipe    <= {dv_pipe[DLY-2:0], div_valid_in};
      dr_pipe[0] <= qdiv(div_num, div_den);
      for (int i = 1; i < DLY; i++) dr_pipe[i] <= dr_pipe[i-1];
    end
  end

  assign div_valid_out = dv_pipe[DLY-1] | force_dvo;
  assign div_result    = dv_pipe[DLY-1] ? dr_pipe[DLY-1] : 32'hDEAD_BEEF;

  typedef struct {
    logic [W-1:0] d;
    logic         dz;
    int           rdy;
  } exp_t;

  exp_t         mq[$];
  exp_t         e;
  logic         m_err    = 1'b0;
  logic         m_junk   = 1'b0;
  logic         acc_prev = 1'b0;
  logic         exp_ov;
  logic         m_acc;
  logic [W-1:0] last_num = '0;
  logic [W-1:0] last_den = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_dz", out_dz, 0);
      chk("rst_err", err, 0);
      chk("rst_div_valid_in", div_valid_in, 0);
      chk("rst_div_num", div_num, 0);
      chk("rst_div_den", div_den, 0);
      mq.delete();
      m_err    = 1'b0;
      m_junk   = 1'b0;
      acc_prev = 1'b0;
    end else begin
      exp_ov = !m_junk && (mq.size() > 0) && (mq[0].rdy <= cyc);
      if (!m_junk) begin
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
          chk("out_data", out_data, mq[0].d);
          chk("out_dz", out_dz, mq[0].dz);
        end
      end
      chk("err", err, m_err);
      chk("div_valid_in", div_valid_in, acc_prev);
      if (acc_prev) begin
        chk("div_num", div_num, last_num);
        chk("div_den", div_den, last_den);
      end
      if (force_dvo) begin
        m_err  = 1'b1;
        m_junk = 1'b1;
      end
      m_acc = in_valid && (mq.size() < DEPTH) && !m_junk;
      if (out_ready && exp_ov) void'(mq.pop_front());
      if (m_acc) begin
        e.d   = ref_q(in_num, in_den);
        e.dz  = (in_den == 0);
        e.rdy = cyc + LAT + 3;  // accepted at the coming edge, readable LAT+2 edges later
        mq.push_back(e);
      end
      acc_prev = m_acc;
      last_num = in_num;
      last_den = (in_den == 0) ? 32'd1 : in_den;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] n, input logic [W-1:0] d);
    logic done;
    int   k;
    done = 1'b0;
    k    = 0;
    in_valid = 1'b1;
    in_num   = n;
    in_den   = d;
    while (!done && k < 40) begin
      @(negedge clk);
      done = in_ready;
      step();
      k++;
    end
    in_valid = 1'b0;
    chk("offer_accepted", done, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 60 && mq.size() != 0; k++) step();
    step();
    chk("drain_idle", out_valid, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_num();
    return ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
  endfunction

  function automatic logic [W-1:0] rnd_den();
    case ($urandom_range(0, 7))
      0:       return '0;
      1, 2:    return W'($signed($urandom_range(0, 510)) - 255);
      default: return W'($urandom);
    endcase
  endfunction

  logic [W-1:0] pn [10];
  logic [W-1:0] pd [10];
  int           idx;
  int           k_lat;
  int           n_acc;
  int           n_pop;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single op latency and value
    out_ready = 1'b1;
    offer(32'h0003_0000, 32'h0001_8000);
    chk("issue_strobe", div_valid_in, 1);
    k_lat = 0;
    while (!out_valid && k_lat < 20) begin
      step();
      k_lat++;
    end
    chk("accept_to_valid_edges", k_lat + 1, LAT + 3);
    chk("first_quotient", out_data, 32'h0002_0000);
    chk("first_dz", out_dz, 0);
    drain();

    // Divide-by-zero substitution
    offer(32'hFFFF_0000, 32'h0);
    chk("dz_den_sub", div_den, 1);
    offer(32'h0, 32'h0);
    offer(32'h0001_0000, 32'h0);
    drain();

    // Backpressure: 10 pairs offered with out_ready low
    for (int i = 0; i < 10; i++) begin
      pn[i] = rnd_num();
      pd[i] = rnd_den();
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 30 && idx < 10; c++) begin
      in_valid = 1'b1;
      in_num   = pn[idx];
      in_den   = pd[idx];
      @(negedge clk);
      if (in_ready) idx++;
      step();
    end
    chk("bp_accepted", idx, 8);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_err", err, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      in_valid = 1'b1;
      in_num   = pn[idx];
      in_den   = pd[idx];
      @(negedge clk);
      if (in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", idx, 10);
    drain();

    // Full reservation, then streaming at one op per cycle
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) offer(rnd_num(), rnd_den());
    repeat (LAT + 4) step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    n_acc = 0;
    n_pop = 0;
    for (int c = 0; c < 24; c++) begin
      in_num = rnd_num();
      in_den = rnd_den();
      @(negedge clk);
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) n_pop++;
      step();
    end
    in_valid = 1'b0;
    chk("stream_accepts", n_acc, 23);
    chk("stream_pops", n_pop, 24);
    drain();

    // Reset with ops in flight
    out_ready = 1'b0;
    offer(32'h0005_0000, 32'h0002_0000);
    offer(32'hFFFE_0000, 32'h0);
    offer(32'h0001_0000, 32'h0003_0000);
    step();
    pulse_rst();
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    step();
    out_ready = 1'b1;
    repeat (12) step();
    chk("post_rst_no_stale", out_valid, 0);
    chk("post_rst_err", err, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_num    = rnd_num();
      in_den    = rnd_den();
      step();
    end
    drain();

    // Spurious divider strobe
    out_ready = 1'b0;
    force_dvo = 1'b1;
    step();
    force_dvo = 1'b0;
    @(negedge clk);
    chk("err_set", err, 1);
    step();
    repeat (5) step();
    chk("err_held", err, 1);
    pulse_rst();
    @(negedge clk);
    chk("err_cleared", err, 0);
    step();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
